// File: rtl/test_pattern_gen_pkg.sv
// Shared mode encodings, bar colour table and stamp width helper for the
// test pattern generator.
package test_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_RAMP  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_MOVE  = 2'd3
   } mode_t;

   // 3-bit {R,G,B} codes: R, G, B, White, Yellow, Cyan, Magenta, Black
   localparam logic [2:0] BAR_COLORS [8] = '{
      3'b100, 3'b010, 3'b001, 3'b111, 3'b110, 3'b011, 3'b101, 3'b000
   };

   function automatic int stamp_width(input int color_width);
      return 3 * color_width;
   endfunction

endpackage

// File: rtl/test_pattern_gen_frame_ctrl.sv
// Frame-level state: boundary detection, frame counter, double-buffered
// pattern mode and moving-bar position.
module tpg_frame_ctrl
   import test_pattern_pkg::*;
#(
   parameter int COLOR_WIDTH   = 12,
   parameter int COUNTER_WIDTH = 12,
   parameter int H_ACTIVE      = 1920,
   parameter int V_TOTAL       = 1125,
   parameter int MOVE_STEP     = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [COUNTER_WIDTH-1:0]             hcount,
   input  logic [COUNTER_WIDTH-1:0]             vcount,
   input  logic [1:0]                           mode_in,
   input  logic                                 mode_wr,
   output logic                                 boundary,
   output logic [stamp_width(COLOR_WIDTH)-1:0]  frame_count,
   output mode_t                                mode_cur,
   output logic [COUNTER_WIDTH-1:0]             move_pos
);

   localparam logic [COUNTER_WIDTH-1:0] V_LAST   = COUNTER_WIDTH'(V_TOTAL - 1);
   localparam logic [COUNTER_WIDTH:0]   STEP_C   = (COUNTER_WIDTH+1)'(MOVE_STEP);
   localparam logic [COUNTER_WIDTH:0]   H_ACT_C  = (COUNTER_WIDTH+1)'(H_ACTIVE);

   mode_t                  mode_pend;
   logic [COUNTER_WIDTH:0] move_sum;

   assign boundary = (hcount == '0) && (vcount == V_LAST);
   assign move_sum = {1'b0, move_pos} + STEP_C;

   // Pending mode tracks every write; frame state advances only at the boundary pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count <= '0;
         mode_pend   <= MODE_BARS;
         mode_cur    <= MODE_BARS;
         move_pos    <= '0;
      end else begin
         if (mode_wr)
            mode_pend <= mode_t'(mode_in);
         if (boundary) begin
            frame_count <= frame_count + 1'b1;
            // a write landing on the boundary itself takes effect immediately
            mode_cur    <= mode_wr ? mode_t'(mode_in) : mode_pend;
            if (move_sum >= H_ACT_C)
               move_pos <= COUNTER_WIDTH'(move_sum - H_ACT_C);
            else
               move_pos <= COUNTER_WIDTH'(move_sum);
         end
      end
   end

endmodule

// File: rtl/test_pattern_gen.sv
// Raster-driven RGB test pattern generator with per-frame stamp pixel.
// Output is registered: one clock from hcount/vcount to pixel.
module test_pattern_gen
   import test_pattern_pkg::*;
#(
   parameter int COLOR_WIDTH   = 12,
   parameter int COUNTER_WIDTH = 12,
   parameter int H_ACTIVE      = 1920,
   parameter int V_ACTIVE      = 1080,
   parameter int V_TOTAL       = 1125,
   parameter int NUM_BARS      = 3,
   parameter int CHECK_LOG2    = 6,
   parameter int MOVE_W        = 64,
   parameter int MOVE_STEP     = 8,
   parameter logic [stamp_width(COLOR_WIDTH)-1:0] STAMP_INIT = 36'hADEADBEEF
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [COUNTER_WIDTH-1:0]             hcount,
   input  logic [COUNTER_WIDTH-1:0]             vcount,
   input  logic [1:0]                           mode_in,
   input  logic                                 mode_wr,
   output logic [COLOR_WIDTH-1:0]               red,
   output logic [COLOR_WIDTH-1:0]               green,
   output logic [COLOR_WIDTH-1:0]               blue,
   output logic                                 active,
   output logic [stamp_width(COLOR_WIDTH)-1:0]  frame_count
);

   localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;
   localparam logic [COUNTER_WIDTH-1:0] H_ACT_C = COUNTER_WIDTH'(H_ACTIVE);
   localparam logic [COUNTER_WIDTH-1:0] V_ACT_C = COUNTER_WIDTH'(V_ACTIVE);
   localparam logic [COUNTER_WIDTH:0]   MOVE_W_C = (COUNTER_WIDTH+1)'(MOVE_W);

   logic                                boundary;
   mode_t                               mode_cur;
   logic [COUNTER_WIDTH-1:0]            move_pos;
   logic [stamp_width(COLOR_WIDTH)-1:0] stamp;
   logic                                in_active;
   logic [2:0]                          bar_idx;
   logic [2:0]                          bar_code;
   logic                                in_move;
   logic [COLOR_WIDTH-1:0]              pix_r, pix_g, pix_b;

   tpg_frame_ctrl #(
      .COLOR_WIDTH   (COLOR_WIDTH),
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .H_ACTIVE      (H_ACTIVE),
      .V_TOTAL       (V_TOTAL),
      .MOVE_STEP     (MOVE_STEP)
   ) u_frame_ctrl (
      .clk         (clk),
      .rst         (rst),
      .hcount      (hcount),
      .vcount      (vcount),
      .mode_in     (mode_in),
      .mode_wr     (mode_wr),
      .boundary    (boundary),
      .frame_count (frame_count),
      .mode_cur    (mode_cur),
      .move_pos    (move_pos)
   );

   assign stamp     = (frame_count == '0) ? STAMP_INIT : frame_count;
   assign in_active = (hcount < H_ACT_C) && (vcount < V_ACT_C);
   assign in_move   = (hcount >= move_pos) &&
                      ({1'b0, hcount} < ({1'b0, move_pos} + MOVE_W_C));
   assign bar_code  = BAR_COLORS[bar_idx];

   // Bar index by threshold compare; the last bar absorbs the division remainder
   always_comb begin
      bar_idx = '0;
      for (int unsigned k = 1; k < NUM_BARS; k++) begin
         if (hcount >= COUNTER_WIDTH'(k * BAR_W))
            bar_idx = 3'(k);
      end
   end

   // Per-pixel colour for the current mode, before blanking and stamp override
   always_comb begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      case (mode_cur)
         MODE_BARS: begin
            pix_r = {COLOR_WIDTH{bar_code[2]}};
            pix_g = {COLOR_WIDTH{bar_code[1]}};
            pix_b = {COLOR_WIDTH{bar_code[0]}};
         end
         MODE_RAMP: begin
            pix_r = COLOR_WIDTH'(hcount);
            pix_g = COLOR_WIDTH'(hcount);
            pix_b = COLOR_WIDTH'(hcount);
         end
         MODE_CHECK: begin
            pix_r = {COLOR_WIDTH{hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2]}};
            pix_g = {COLOR_WIDTH{hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2]}};
            pix_b = {COLOR_WIDTH{hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2]}};
         end
         MODE_MOVE: begin
            pix_r = {COLOR_WIDTH{in_move}};
            pix_g = {COLOR_WIDTH{in_move}};
            pix_b = {COLOR_WIDTH{in_move}};
         end
         default: ;
      endcase
   end

   // Output register: stamp wins over everything, then blanking, then pattern
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red    <= '0;
         green  <= '0;
         blue   <= '0;
         active <= 1'b0;
      end else if (boundary) begin
         {red, green, blue} <= stamp;
         active             <= 1'b0;
      end else if (in_active) begin
         red    <= pix_r;
         green  <= pix_g;
         blue   <= pix_b;
         active <= 1'b1;
      end else begin
         red    <= '0;
         green  <= '0;
         blue   <= '0;
         active <= 1'b0;
      end
   end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed, table-driven bench for test_pattern_gen at default parameters.
module tb_test_pattern_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] hcount, vcount;
   logic [1:0]  mode_in;
   logic        mode_wr;
   logic [11:0] red, green, blue;
   logic        active;
   logic [35:0] frame_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] h;
      logic [11:0] v;
      logic [36:0] exp;   // {red, green, blue, active}
      string       name;
   } vec_t;

   vec_t vecs [9];

   test_pattern_gen dut (
      .clk         (clk),
      .rst         (rst),
      .hcount      (hcount),
      .vcount      (vcount),
      .mode_in     (mode_in),
      .mode_wr     (mode_wr),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .active      (active),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_pix(input string name, input logic [36:0] exp);
      chk(name, {27'd0, red, green, blue, active}, {27'd0, exp});
   endtask

   // present one pixel, clock it, land 1 time unit after the edge
   task automatic step(input logic [11:0] h, input logic [11:0] v,
                       input logic wr, input logic [1:0] m);
      hcount  = h;
      vcount  = v;
      mode_wr = wr;
      mode_in = m;
      @(posedge clk);
      #1;
      mode_wr = 1'b0;
   endtask

   task automatic frame_b(input logic wr, input logic [1:0] m);
      step(12'd0, 12'd1124, wr, m);
   endtask

   initial begin
      vecs[0] = '{12'd0,    12'd10,   {36'hFFF000000, 1'b1}, "bar0 h0"};
      vecs[1] = '{12'd639,  12'd10,   {36'hFFF000000, 1'b1}, "bar0 h639"};
      vecs[2] = '{12'd640,  12'd10,   {36'h000FFF000, 1'b1}, "bar1 h640"};
      vecs[3] = '{12'd1279, 12'd10,   {36'h000FFF000, 1'b1}, "bar1 h1279"};
      vecs[4] = '{12'd1280, 12'd10,   {36'h000000FFF, 1'b1}, "bar2 h1280"};
      vecs[5] = '{12'd1919, 12'd10,   {36'h000000FFF, 1'b1}, "bar2 h1919"};
      vecs[6] = '{12'd1920, 12'd10,   37'h0,                 "hblank h1920"};
      vecs[7] = '{12'd5,    12'd1080, 37'h0,                 "vblank v1080"};
      vecs[8] = '{12'd1,    12'd1124, 37'h0,                 "last line not B"};

      rst = 1'b1; hcount = '0; vcount = '0; mode_in = '0; mode_wr = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk_pix("reset pixel", 37'h0);
      chk("reset frame_count", {28'd0, frame_count}, 64'd0);
      rst = 1'b0;

      // mode 0 bars sweep
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].h, vecs[i].v, 1'b0, 2'd0);
         chk_pix(vecs[i].name, vecs[i].exp);
      end

      // three frames: stamp sequence and counter
      frame_b(1'b0, 2'd0);
      chk_pix("stamp frame0", {36'hADEADBEEF, 1'b0});
      chk("fc after 1", {28'd0, frame_count}, 64'd1);
      frame_b(1'b0, 2'd0);
      chk_pix("stamp frame1", {36'h000000001, 1'b0});
      frame_b(1'b0, 2'd0);
      chk_pix("stamp frame2", {36'h000000002, 1'b0});
      chk("fc after 3", {28'd0, frame_count}, 64'd3);

      // mid-frame mode write waits for the boundary
      step(12'd100, 12'd10, 1'b1, 2'd2);
      step(12'd64, 12'd0, 1'b0, 2'd0);
      chk_pix("pending not applied", {36'hFFF000000, 1'b1});
      frame_b(1'b0, 2'd0);
      chk_pix("stamp frame3", {36'h000000003, 1'b0});
      step(12'd64, 12'd0, 1'b0, 2'd0);
      chk_pix("check (64,0)", {36'hFFFFFFFFF, 1'b1});
      step(12'd64, 12'd64, 1'b0, 2'd0);
      chk_pix("check (64,64)", {36'h000000000, 1'b1});

      // ramp
      step(12'd50, 12'd10, 1'b1, 2'd1);
      frame_b(1'b0, 2'd0);
      chk_pix("stamp frame4", {36'h000000004, 1'b0});
      step(12'd1234, 12'd10, 1'b0, 2'd0);
      chk_pix("ramp h1234", {36'h4D24D24D2, 1'b1});

      // async reset mid-line, with a pending mode that must be discarded
      step(12'd1235, 12'd10, 1'b1, 2'd2);
      rst = 1'b1;
      #1;
      chk_pix("async reset pixel", 37'h0);
      chk("async reset fc", {28'd0, frame_count}, 64'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;

      frame_b(1'b0, 2'd0);
      chk_pix("stamp after reset", {36'hADEADBEEF, 1'b0});
      chk("fc after reset B", {28'd0, frame_count}, 64'd1);
      step(12'd0, 12'd10, 1'b0, 2'd0);
      chk_pix("bars after reset", {36'hFFF000000, 1'b1});

      // mode write on the boundary itself: move_pos 8 -> 16, mode 3 at once
      frame_b(1'b1, 2'd3);
      chk_pix("stamp bypass B", {36'h000000001, 1'b0});
      step(12'd15, 12'd10, 1'b0, 2'd0);
      chk_pix("move h15 black", {36'h000000000, 1'b1});
      step(12'd16, 12'd10, 1'b0, 2'd0);
      chk_pix("move h16 white", {36'hFFFFFFFFF, 1'b1});
      step(12'd79, 12'd10, 1'b0, 2'd0);
      chk_pix("move h79 white", {36'hFFFFFFFFF, 1'b1});
      step(12'd80, 12'd10, 1'b0, 2'd0);
      chk_pix("move h80 black", {36'h000000000, 1'b1});

      // 238 more frames: 16 + 8*238 = 1920 wraps to 0
      for (int i = 0; i < 238; i++)
         frame_b(1'b0, 2'd0);
      chk_pix("stamp frame239", {36'd239, 1'b0});
      chk("fc 240", {28'd0, frame_count}, 64'd240);
      step(12'd0, 12'd10, 1'b0, 2'd0);
      chk_pix("wrap h0 white", {36'hFFFFFFFFF, 1'b1});
      step(12'd63, 12'd10, 1'b0, 2'd0);
      chk_pix("wrap h63 white", {36'hFFFFFFFFF, 1'b1});
      step(12'd64, 12'd10, 1'b0, 2'd0);
      chk_pix("wrap h64 black", {36'h000000000, 1'b1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/test_pattern_gen.md
Name: test_pattern_gen

Overview:
Parametrised successor to the fixed RGB colour-bar pixel generator in the test video source. It turns raster counters into registered RGB pixel data in one of four selectable patterns. It embeds a per-frame stamp word on the frame-boundary pixel and keeps a free-running frame counter. It sits between the video timing generator (hcount/vcount source) and the output formatter.

Parameters:
COLOR_WIDTH, 12, bits per colour channel
COUNTER_WIDTH, 12, width of hcount/vcount
H_ACTIVE, 1920, active pixels per line
V_ACTIVE, 1080, active lines per frame
V_TOTAL, 1125, total lines per frame; the stamp pixel is at line V_TOTAL-1
NUM_BARS, 3, colour bars in mode 0, range 1..8
CHECK_LOG2, 6, checkerboard square size is 2^CHECK_LOG2 pixels
MOVE_W, 64, moving-bar width in pixels
MOVE_STEP, 8, moving-bar advance per frame in pixels
STAMP_INIT, 36'hADEADBEEF, stamp word used while frame_count==0 (3*COLOR_WIDTH bits)

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-high
hcount  in  COUNTER_WIDTH  horizontal pixel counter
vcount  in  COUNTER_WIDTH  vertical line counter
mode_in  in  2  requested pattern mode
mode_wr  in  1  one-cycle strobe that loads mode_in into the pending register
red  out  COLOR_WIDTH  red pixel (registered)
green  out  COLOR_WIDTH  green pixel (registered)
blue  out  COLOR_WIDTH  blue pixel (registered)
active  out  1  registered: pixel was inside H_ACTIVE x V_ACTIVE
frame_count  out  3*COLOR_WIDTH  frames completed, wraps modulo 2^(3*COLOR_WIDTH)

Behaviour:
- Reset (async assert, sync release): red/green/blue/active=0, frame_count=0, mode_cur=0, mode_pend=0, move_pos=0.
- Latency: exactly 1 clk. Outputs at cycle n+1 reflect hcount/vcount at cycle n.
- Boundary pixel B: hcount==0 && vcount==V_TOTAL-1.
- At B:
  - the output is the stamp: {red,green,blue} = (frame_count==0) ? STAMP_INIT : frame_count, using the value before increment.
  - frame_count increments.
  - mode_cur <= mode_pend.
  - move_pos <= (move_pos+MOVE_STEP >= H_ACTIVE) ? move_pos+MOVE_STEP-H_ACTIVE : move_pos+MOVE_STEP.
- The stamp overrides every mode and the active check. active=0 for B.
- mode_wr on any cycle: mode_pend <= mode_in. If mode_wr coincides with B, the new mode_in applies from this boundary (bypass).
- Outside the active area (except B): all colours 0, active=0.
- Mode 0, bars:
  - BAR_W = H_ACTIVE/NUM_BARS (integer). Bar k covers [k*BAR_W, (k+1)*BAR_W-1]; the last bar extends to H_ACTIVE-1.
  - Colour table, index 0..7: R, G, B, White, Yellow, Cyan, Magenta, Black. Each component is all-ones or 0.
  - NUM_BARS=3 reproduces the legacy red/green/blue pattern.
- Mode 1, ramp: all channels = hcount zero-extended or truncated to COLOR_WIDTH (wraps).
- Mode 2, checkerboard: white if hcount[CHECK_LOG2]^vcount[CHECK_LOG2], else black.
- Mode 3, moving bar: white if move_pos <= hcount < move_pos+MOVE_W (no wrap of the bar itself), else black.
- Reset mid-frame: the next B increments 0->1 and emits STAMP_INIT. A mode written before reset is lost.
- hcount/vcount values beyond the totals are treated as blanking (zero output), except B.

Decomposition:
- Package test_pattern_pkg holds:
  - mode encodings (MODE_BARS=0, MODE_RAMP=1, MODE_CHECK=2, MODE_MOVE=3)
  - the 8-entry bar colour table (3-bit RGB codes)
  - the STAMP width function 3*COLOR_WIDTH.
- One sub-module, tpg_frame_ctrl, holds frame_count, mode_pend/mode_cur, move_pos and boundary detection. The top holds per-pixel pattern selection and the output register.

Test Plan:
- Reset then raster sweep in mode 0, NUM_BARS=3 -> at hcount 0/639/640/1279/1280/1919 (vcount 10), one cycle later RGB = FFF,000,000 / FFF,000,000 / 000,FFF,000 / 000,FFF,000 / 000,000,FFF / 000,000,FFF; hcount 1920 -> 0, active=0.
- Three full frames -> stamp at B is ADE/ADB/EEF, then 000/000/001, then 000/000/002; frame_count reads 3 afterwards.
- mode_wr with mode_in=2 mid-frame -> bars continue until B, then pixel (64,0) = FFF and pixel (64,64) = 000. A second test pulses mode_wr exactly at B and requires the switch on the same boundary.
- Mode 3, MOVE_STEP=8 -> frame 0 white at hcount 0..63; after 1 frame white at 8..71; after 240 frames move_pos wraps to 0.
- Mode 1 -> hcount 1234 gives all channels 12'h4D2. Assert rst mid-line -> outputs 0 asynchronously. After release the next B emits ADEADBEEF and mode reverts to bars.
